// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between the I-cache fill FSM and
// the D-cache fill/write-back FSM; one burst at a time, responses to owner only.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_ic_start_read,
  input  logic [ADDR_WIDTH-1:0] i_ic_addr,
  output logic                  o_ic_r_valid,
  output logic                  o_ic_r_last,
  input  logic                  i_dc_start_read,
  input  logic                  i_dc_start_write,
  input  logic [ADDR_WIDTH-1:0] i_dc_addr,
  output logic                  o_dc_r_valid,
  output logic                  o_dc_r_last,
  output logic                  o_dc_b_resp,
  output logic                  o_mem_start_read,
  output logic                  o_mem_start_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_r_valid,
  input  logic                  i_mem_r_last,
  input  logic                  i_mem_b_resp,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, GRANT_IC, GRANT_DC_RD, GRANT_DC_WR} state_t;

  state_t state, state_nxt;
  logic   last_dc;

  always_ff @(posedge clk) begin
    if (arst) begin
      state   <= IDLE;
      last_dc <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE)
        last_dc <= (state_nxt != GRANT_IC);
    end
  end

  // Write-back first: it holds the victim line the dependent fill waits on.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_dc_start_write)                        state_nxt = GRANT_DC_WR;
        else if (i_dc_start_read && i_ic_start_read) state_nxt = last_dc ? GRANT_IC : GRANT_DC_RD;
        else if (i_dc_start_read)                    state_nxt = GRANT_DC_RD;
        else if (i_ic_start_read)                    state_nxt = GRANT_IC;
      end
      GRANT_IC, GRANT_DC_RD: if (i_mem_r_last) state_nxt = IDLE;
      GRANT_DC_WR:           if (i_mem_b_resp) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Outputs come from the registered state only; requesters dropping their
  // level mid-burst cannot abort a burst the master already started.
  always_comb begin
    o_mem_start_read  = 1'b0;
    o_mem_start_write = 1'b0;
    o_mem_addr        = '0;
    o_ic_r_valid      = 1'b0;
    o_ic_r_last       = 1'b0;
    o_dc_r_valid      = 1'b0;
    o_dc_r_last       = 1'b0;
    o_dc_b_resp       = 1'b0;
    o_busy            = (state != IDLE);
    case (state)
      GRANT_IC: begin
        o_mem_start_read = 1'b1;
        o_mem_addr       = i_ic_addr;
        o_ic_r_valid     = i_mem_r_valid;
        o_ic_r_last      = i_mem_r_last;
      end
      GRANT_DC_RD: begin
        o_mem_start_read = 1'b1;
        o_mem_addr       = i_dc_addr;
        o_dc_r_valid     = i_mem_r_valid;
        o_dc_r_last      = i_mem_r_last;
      end
      GRANT_DC_WR: begin
        o_mem_start_write = 1'b1;
        o_mem_addr        = i_dc_addr;
        o_dc_b_resp       = i_mem_b_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, routing, stray strobes,
// requester drop and reset behaviour, checked with immediate assertions.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam logic [AW-1:0] IC_A = 64'h1000;
  localparam logic [AW-1:0] DC_A = 64'h2000;

  logic clk = 1'b0;
  logic arst;
  logic ic_rd, dc_rd, dc_wr;
  logic [AW-1:0] ic_addr, dc_addr;
  logic ic_r_valid, ic_r_last, dc_r_valid, dc_r_last, dc_b_resp;
  logic mem_rd, mem_wr, busy;
  logic [AW-1:0] mem_addr;
  logic r_valid, r_last, b_resp;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .arst(arst),
    .i_ic_start_read(ic_rd), .i_ic_addr(ic_addr),
    .o_ic_r_valid(ic_r_valid), .o_ic_r_last(ic_r_last),
    .i_dc_start_read(dc_rd), .i_dc_start_write(dc_wr), .i_dc_addr(dc_addr),
    .o_dc_r_valid(dc_r_valid), .o_dc_r_last(dc_r_last), .o_dc_b_resp(dc_b_resp),
    .o_mem_start_read(mem_rd), .o_mem_start_write(mem_wr), .o_mem_addr(mem_addr),
    .i_mem_r_valid(r_valid), .i_mem_r_last(r_last), .i_mem_b_resp(b_resp),
    .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read 1 ns later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expect a read grant to the given owner, then finish it with one last beat.
  task automatic read_grant(input string tag, input logic exp_ic);
    settle();
    chk({tag, "_rd"}, mem_rd, 1'b1);
    chk({tag, "_addr"}, mem_addr, exp_ic ? IC_A : DC_A);
    r_valid = 1'b1; r_last = 1'b1;
    settle();
    chk({tag, "_ic_last"}, ic_r_last, exp_ic);
    chk({tag, "_dc_last"}, dc_r_last, !exp_ic);
    step();
    r_valid = 1'b0; r_last = 1'b0;
    settle();
    chk({tag, "_bubble"}, busy, 1'b0);
    step();
  endtask

  initial begin
    int nv, nl;
    arst = 1'b1; ic_addr = IC_A; dc_addr = DC_A;
    ic_rd = 1'b1; dc_rd = 1'b1; dc_wr = 1'b1;
    r_valid = 1'b0; r_last = 1'b0; b_resp = 1'b0;

    // Reset with every request high
    step(); step();
    settle();
    chk("rst_rd", mem_rd, 1'b0);
    chk("rst_wr", mem_wr, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_busy", busy, 1'b0);
    arst = 1'b0;
    step();
    settle();
    chk("rst_wr_grant", mem_wr, 1'b1);
    chk("rst_wr_addr", mem_addr, DC_A);
    chk("rst_wr_nord", mem_rd, 1'b0);
    b_resp = 1'b1; ic_rd = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
    settle();
    chk("rst_bresp", dc_b_resp, 1'b1);
    step();
    b_resp = 1'b0;
    settle();
    chk("rst_release", busy, 1'b0);

    // Single I-fill of four beats
    ic_rd = 1'b1;
    step();
    settle();
    chk("ifill_rd", mem_rd, 1'b1);
    chk("ifill_addr", mem_addr, IC_A);
    nv = 0; nl = 0;
    for (int b = 1; b <= 4; b++) begin
      r_valid = 1'b1; r_last = (b == 4);
      if (b == 4) ic_rd = 1'b0;
      settle();
      nv += int'(ic_r_valid); nl += int'(ic_r_last);
      chk("ifill_dc_valid", dc_r_valid, 1'b0);
      step();
    end
    r_valid = 1'b0; r_last = 1'b0;
    settle();
    chk("ifill_nvalid", nv, 4);
    chk("ifill_nlast", nl, 1);
    chk("ifill_idle", busy, 1'b0);

    // Contention from reset: DC, IC, DC, IC
    arst = 1'b1;
    step();
    arst = 1'b0; ic_rd = 1'b1; dc_rd = 1'b1;
    settle();
    chk("cont_rst_idle", busy, 1'b0);
    step();
    read_grant("cont1_dc", 1'b0);
    read_grant("cont2_ic", 1'b1);
    read_grant("cont3_dc", 1'b0);
    ic_rd = 1'b0; dc_rd = 1'b0;
    settle();
    chk("cont4_rd", mem_rd, 1'b1);
    chk("cont4_addr", mem_addr, IC_A);
    r_valid = 1'b1; r_last = 1'b1;
    step();
    r_valid = 1'b0; r_last = 1'b0;
    settle();
    chk("cont4_idle", busy, 1'b0);

    // Write-back, then IC wins over the DC fill because last_dc=1
    dc_wr = 1'b1; ic_rd = 1'b1;
    step();
    settle();
    chk("wb_wr", mem_wr, 1'b1);
    b_resp = 1'b1;
    settle();
    chk("wb_bresp", dc_b_resp, 1'b1);
    step();
    b_resp = 1'b0; dc_wr = 1'b0; dc_rd = 1'b1;
    settle();
    chk("wb_bresp_pulse", dc_b_resp, 1'b0);
    chk("wb_idle", busy, 1'b0);
    step();
    read_grant("wb_ic", 1'b1);
    ic_rd = 1'b0;
    settle();
    chk("wb_dc_rd", mem_rd, 1'b1);
    chk("wb_dc_addr", mem_addr, DC_A);
    r_valid = 1'b1; r_last = 1'b1; dc_rd = 1'b0;
    step();
    r_valid = 1'b0; r_last = 1'b0;

    // Stray strobes in IDLE and during a write grant
    r_valid = 1'b1; r_last = 1'b1;
    settle();
    chk("stray_idle_ic", ic_r_last, 1'b0);
    chk("stray_idle_dc", dc_r_last, 1'b0);
    step();
    r_valid = 1'b0; r_last = 1'b0;
    settle();
    chk("stray_idle_busy", busy, 1'b0);
    dc_wr = 1'b1;
    step();
    dc_wr = 1'b0; r_valid = 1'b1; r_last = 1'b1;
    settle();
    chk("stray_wr_dclast", dc_r_last, 1'b0);
    chk("stray_wr_iclast", ic_r_last, 1'b0);
    chk("stray_wr_dcvalid", dc_r_valid, 1'b0);
    step();
    r_valid = 1'b0; r_last = 1'b0;
    settle();
    chk("stray_wr_hold", mem_wr, 1'b1);
    b_resp = 1'b1;
    step();
    b_resp = 1'b0;
    settle();
    chk("stray_wr_done", busy, 1'b0);

    // Requester drops after beat 2; grant holds until r_last
    ic_rd = 1'b1;
    step();
    for (int b = 1; b <= 2; b++) begin
      r_valid = 1'b1;
      step();
    end
    r_valid = 1'b0; ic_rd = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("drop_hold", mem_rd, 1'b1);
      step();
    end
    r_valid = 1'b1; r_last = 1'b1;
    settle();
    chk("drop_last", ic_r_last, 1'b1);
    step();
    r_valid = 1'b0; r_last = 1'b0;
    settle();
    chk("drop_idle", mem_rd, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
